uart_rx_lite: RTL and testbench
===============================

UART_RX_LITE -- requirements
Module: uart_rx_lite

Interface
REQ-001 SHALL have parameter Width, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter logic ResetLine, default 1'b1, synchronizer reset value (idle-high line).
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tick_i  input  1  one-cycle strobe at 16x baud rate.
REQ-006 SHALL have port rx_enable_i  input  1  receiver enable.
REQ-007 SHALL have port rx_i  input  1  asynchronous serial line.
REQ-008 SHALL have port parity_odd_i  input  1  parity sense, 1=odd (present only with UART_RX_PARITY_EN).
REQ-009 SHALL have port data_o  output  Width  last received word.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse, good frame in data_o.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse, stop bit sampled 0.
REQ-012 SHALL have port parity_err_o  output  1  one-cycle pulse, parity mismatch (tied 0 without macro).
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer before any use; sampled value called rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-016 IDLE: on rxs==0 with rx_enable_i==1 go START and clear 4-bit oversample count.
REQ-017 Oversample count SHALL increment only on tick_i, wrapping 15->0.
REQ-018 START: on tick with count==7, rxs==1 -> IDLE (glitch reject, no outputs); rxs==0 -> DATA with count cleared, bit index 0.
REQ-019 DATA: on tick with count==15, shift rxs in LSB-first; after bit Width-1 go PARITY (macro defined) or STOP.
REQ-020 PARITY: on tick with count==15 compare rxs to XOR of data bits XOR parity_odd_i; go STOP, latching mismatch.
REQ-021 STOP: on tick with count==15 load data_o; rxs==1 and no parity mismatch -> valid_o pulse, IDLE.
REQ-022 STOP with rxs==1 and parity mismatch: parity_err_o pulse, no valid_o, IDLE.
REQ-023 STOP with rxs==0: frame_err_o pulse (parity_err_o also if mismatch), no valid_o, go WAIT_HIGH; WAIT_HIGH -> IDLE when rxs==1.
REQ-024 Output pulses SHALL assert the clk_i cycle after the stop-bit sampling tick and last exactly one cycle.
REQ-025 data_o SHALL hold its value until the next stop-bit sample; valid_o and error pulses SHALL be mutually exclusive with each other except frame+parity.
REQ-026 rx_enable_i deasserting in any state SHALL force IDLE next cycle, discard partial word, emit no pulse.
REQ-027 tick_i absent SHALL freeze all counters; back-to-back frames (start bit directly after stop) SHALL be received without loss.

Reset
REQ-028 rst_i SHALL asynchronously set state IDLE, counters 0, synchronizer flops ResetLine, data_o 0, valid_o/frame_err_o/parity_err_o/busy_o 0.
REQ-029 rst_i asserted mid-frame SHALL abort the frame with no pulse after release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state, parity_odd_i and live parity_err_o present; frame = start+Width+parity+stop.
REQ-031 Macro undefined: PARITY state and parity_odd_i removed, parity_err_o tied 0, frame = start+Width+stop.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the state enum, OvsRate=16, OvsMid=7, OvsLast=15.
REQ-033 Synchronizer SHALL be sub-module uart_rx_sync (2-stage, parameterised reset value, async active-high reset).

Verification
REQ-034 Frame 0xA5, 8N1, 16 ticks/bit -> data_o=0xA5, one valid_o pulse, no errors.
REQ-035 rx_i low for 4 ticks then high -> return to IDLE, no pulses, busy_o drops.
REQ-036 Frame 0x3C with stop bit 0, line high 2 bits later -> frame_err_o pulse, data_o=0x3C, WAIT_HIGH then IDLE.
REQ-037 Macro on, parity_odd_i=0, frame 0x01 with parity bit 0 -> parity_err_o pulse, no valid_o.
REQ-038 rst_i pulsed after 4th data bit of 0xFF, then frame 0x5A -> only 0x5A reported with one valid_o.
REQ-039 Back-to-back 0x00 then 0xFF, no idle gap -> two valid_o pulses, 160 ticks apart, correct data.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared FSM encoding and oversampling constants for uart_rx_lite.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int OvsRate = 16;
    localparam int OvsMid  = 7;
    localparam int OvsLast = 15;
    localparam int OvsW    = $clog2(OvsRate);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : Two-stage synchronizer for the asynchronous serial line.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter logic ResetLine = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= ResetLine;
            r_sync <= ResetLine;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_lite.sv
// ============================================================================
//  Module   : uart_rx_lite
//  Brief    : 16x oversampling UART receiver; optional parity via the
//             UART_RX_PARITY_EN macro (adds parity_odd_i and PARITY state).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_lite
    import uart_rx_pkg::*;
#(
    parameter int   Width     = 8,
    parameter logic ResetLine = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             rx_enable_i,
    input  logic             rx_i,
`ifdef UART_RX_PARITY_EN
    input  logic             parity_odd_i,
`endif
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             busy_o
);

    logic            w_rxs;
    rx_state_e       r_state;
    rx_state_e       w_state_nxt;
    logic [OvsW-1:0] r_ovs;
    logic [OvsW-1:0] w_ovs_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_nxt;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] w_shift_nxt;
    logic            w_par_err;
    logic            w_stop_sample;
    logic            w_valid_nxt;
    logic            w_ferr_nxt;
    logic            r_valid;
    logic            r_ferr;

    uart_rx_sync #(
        .ResetLine (ResetLine)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (w_rxs)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic w_par_nxt;
    logic r_perr;
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_ovs     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            data_o    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ovs     <= w_ovs_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
            if (w_stop_sample) begin
                data_o <= r_shift;
            end
`ifdef UART_RX_PARITY_EN
            r_par_err <= w_par_nxt;
            r_perr    <= w_stop_sample & r_par_err;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ovs_nxt   = r_ovs;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_err;
`endif
        if (tick_i && (r_state != ST_IDLE) && (r_state != ST_WAIT_HIGH)) begin
            w_ovs_nxt = r_ovs + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_rxs && rx_enable_i) begin
                    w_state_nxt = ST_START;
                    w_ovs_nxt   = '0;
                    w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                    w_par_nxt   = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick_i && (r_ovs == OvsW'(OvsMid))) begin
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_ovs_nxt   = '0;
                        w_bit_nxt   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick_i && (r_ovs == OvsW'(OvsLast))) begin
                    w_shift_nxt = {w_rxs, r_shift[Width-1:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'(Width - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_i && (r_ovs == OvsW'(OvsLast))) begin
                    // Expected bit is XOR of data XOR sense; any difference is a mismatch
                    w_par_nxt   = w_rxs ^ (^r_shift) ^ parity_odd_i;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_i && (r_ovs == OvsW'(OvsLast))) begin
                    w_state_nxt = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (!rx_enable_i) begin
            w_state_nxt = ST_IDLE;
            w_ovs_nxt   = '0;
            w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
            w_par_nxt   = 1'b0;
`endif
        end
    end

    // Output decode
    always_comb begin
        w_stop_sample = (r_state == ST_STOP) && tick_i &&
                        (r_ovs == OvsW'(OvsLast)) && rx_enable_i;
        w_valid_nxt   = w_stop_sample & w_rxs & ~w_par_err;
        w_ferr_nxt    = w_stop_sample & ~w_rxs;
    end

    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_perr;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_lite.sv
// ============================================================================
//  Module   : tb_uart_rx_lite
//  Brief    : Directed self-checking bench for uart_rx_lite.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_lite;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_i = 1'b0;
    logic       rx_enable_i = 1'b1;
    logic       rx_i = 1'b1;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd_i = 1'b0;
`endif
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       busy_o;

    int n_checks = 0;
    int n_bad    = 0;
    int tick_cnt = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    logic [7:0] v_data [16];
    int         v_tick [16];

    uart_rx_lite #(
        .Width     (8),
        .ResetLine (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick_i),
        .rx_enable_i  (rx_enable_i),
        .rx_i         (rx_i),
`ifdef UART_RX_PARITY_EN
        .parity_odd_i (parity_odd_i),
`endif
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (valid_o) begin
            v_data[n_valid[3:0]] = data_o;
            v_tick[n_valid[3:0]] = tick_cnt;
            n_valid = n_valid + 1;
        end
        if (frame_err_o)  n_ferr = n_ferr + 1;
        if (parity_err_o) n_perr = n_perr + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        tick_i   = 1'b1;
        tick_cnt = tick_cnt + 1;
        @(posedge clk); #1;
        tick_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (16) do_tick();
    endtask

    task automatic idle_ticks(input int n);
        rx_i = 1'b1;
        repeat (n) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ parity_odd_i ^ flip_par);
`else
        if (flip_par) begin end
`endif
        send_bit(stop_b);
    endtask

    initial begin
        int base_v;
        int base_f;
        int base_p;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_data",  {24'd0, data_o}, 32'h00);
        check_eq("reset_valid", {31'd0, valid_o}, 32'd0);
        check_eq("reset_ferr",  {31'd0, frame_err_o}, 32'd0);
        check_eq("reset_perr",  {31'd0, parity_err_o}, 32'd0);
        check_eq("reset_busy",  {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        idle_ticks(4);

        // Good frame 0xA5
        base_v = n_valid; base_f = n_ferr; base_p = n_perr;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_ticks(4);
        check_eq("a5_valid_cnt", n_valid - base_v, 1);
        check_eq("a5_data",      {24'd0, data_o}, 32'hA5);
        check_eq("a5_ferr_cnt",  n_ferr - base_f, 0);
        check_eq("a5_perr_cnt",  n_perr - base_p, 0);
        check_eq("a5_busy",      {31'd0, busy_o}, 32'd0);

        // Start-bit glitch
        base_v = n_valid; base_f = n_ferr;
        rx_i = 1'b0;
        repeat (4) do_tick();
        check_eq("glitch_busy_hi", {31'd0, busy_o}, 32'd1);
        idle_ticks(8);
        check_eq("glitch_busy_lo", {31'd0, busy_o}, 32'd0);
        check_eq("glitch_pulses",  (n_valid - base_v) + (n_ferr - base_f), 0);

        // Framing error 0x3C, line held low one extra bit
        base_v = n_valid; base_f = n_ferr; base_p = n_perr;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0);
        check_eq("ferr_cnt",       n_ferr - base_f, 1);
        check_eq("ferr_data",      {24'd0, data_o}, 32'h3C);
        check_eq("ferr_no_valid",  n_valid - base_v, 0);
        check_eq("ferr_no_perr",   n_perr - base_p, 0);
        check_eq("ferr_wait_busy", {31'd0, busy_o}, 32'd1);
        idle_ticks(2);
        check_eq("ferr_idle",      {31'd0, busy_o}, 32'd0);

        // Reset mid-frame of 0xFF, then 0x5A
        idle_ticks(4);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_mid_data", {24'd0, data_o}, 32'h00);
        idle_ticks(20);
        base_v = n_valid; base_f = n_ferr;
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_ticks(4);
        check_eq("rst_5a_valid_cnt", n_valid - base_v, 1);
        check_eq("rst_5a_data",      {24'd0, v_data[base_v[3:0]]}, 32'h5A);
        check_eq("rst_5a_ferr",      n_ferr - base_f, 0);

        // Back-to-back 0x00 then 0xFF
        base_v = n_valid;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_ticks(4);
        check_eq("b2b_valid_cnt", n_valid - base_v, 2);
        check_eq("b2b_data0",     {24'd0, v_data[base_v[3:0]]}, 32'h00);
        check_eq("b2b_data1",     {24'd0, v_data[4'(base_v + 1)]}, 32'hFF);
`ifdef UART_RX_PARITY_EN
        check_eq("b2b_spacing",   v_tick[4'(base_v + 1)] - v_tick[base_v[3:0]], 176);
`else
        check_eq("b2b_spacing",   v_tick[4'(base_v + 1)] - v_tick[base_v[3:0]], 160);
`endif

        // Enable dropped mid-frame
        base_v = n_valid; base_f = n_ferr; base_p = n_perr;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check_eq("en_busy_before", {31'd0, busy_o}, 32'd1);
        rx_enable_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("en_busy_after", {31'd0, busy_o}, 32'd0);
        idle_ticks(2);
        rx_enable_i = 1'b1;
        idle_ticks(20);
        check_eq("en_no_pulse", (n_valid - base_v) + (n_ferr - base_f) + (n_perr - base_p), 0);

`ifdef UART_RX_PARITY_EN
        // Parity error: even sense, 0x01 with parity bit 0
        base_v = n_valid; base_p = n_perr; base_f = n_ferr;
        parity_odd_i = 1'b0;
        send_frame(8'h01, 1'b1, 1'b1);
        idle_ticks(4);
        check_eq("par_err_cnt",  n_perr - base_p, 1);
        check_eq("par_no_valid", n_valid - base_v, 0);
        check_eq("par_no_ferr",  n_ferr - base_f, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
